// File: rtl/bpsk_tx_stream.sv
// BPSK/DBPSK stream transmitter: valid/ready words in, square-wave
// carrier out with one queued word for gapless back-to-back frames.
module bpsk_tx_stream #(
  parameter int CLOCK_IN      = 20_000_000,
  parameter int CLOCK_CARRIER = 64_000,
  parameter int DATA_WIDTH    = 8,
  parameter int CYCLE_COUNT   = 4,
  parameter bit MSB_FIRST     = 1'b0,
  parameter bit DIFFERENTIAL  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  wave_out,
  output logic                  busy,
  output logic                  bit_strobe,
  output logic                  word_done
);

  localparam int HALF_DIV = CLOCK_IN / (2 * CLOCK_CARRIER);
  localparam int HALVES   = 2 * CYCLE_COUNT;
  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int HW = (HALVES > 1) ? $clog2(HALVES) : 1;
  localparam int IW = $clog2(DATA_WIDTH);

  localparam logic [CW-1:0] CLK_LAST  = CW'(HALF_DIV - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(HALVES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t state, state_nx;

  logic                  buf_full, buf_full_nx;
  logic [DATA_WIDTH-1:0] buf_data, buf_data_nx;
  logic [DATA_WIDTH-1:0] shreg, shreg_nx;
  logic [IW-1:0]         bit_idx, bit_idx_nx;
  logic [CW-1:0]         clk_cnt, clk_cnt_nx;
  logic [HW-1:0]         half_cnt, half_cnt_nx;
  logic                  carrier, carrier_nx;
  logic                  phase, phase_nx;

  logic                  xfer;
  logic                  clk_term;
  logic                  half_term;
  logic                  last_bit;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_word;

  function automatic logic pick(
    input logic [DATA_WIDTH-1:0] w,
    input logic [IW-1:0]         k
  );
    logic [IW-1:0] j;
    j = MSB_FIRST ? (IDX_LAST - k) : k;
    return w[j];
  endfunction

  function automatic logic coded(
    input logic ref_ph,
    input logic b
  );
    return DIFFERENTIAL ? (ref_ph ^ b) : b;
  endfunction

  assign s_ready   = !rst && !buf_full;
  assign xfer      = s_valid && s_ready;
  assign busy      = (state == SEND);
  assign wave_out  = busy & (carrier ^ phase);

  assign clk_term  = (clk_cnt == CLK_LAST);
  assign half_term = (half_cnt == HALF_LAST);
  assign last_bit  = (bit_idx == IDX_LAST);

  assign bit_strobe = busy && enable &&
                      (clk_cnt == '0) && (half_cnt == '0);
  assign word_done  = busy && enable &&
                      clk_term && half_term && last_bit;

  always_comb begin
    state_nx    = state;
    buf_full_nx = buf_full;
    buf_data_nx = buf_data;
    shreg_nx    = shreg;
    bit_idx_nx  = bit_idx;
    clk_cnt_nx  = clk_cnt;
    half_cnt_nx = half_cnt;
    carrier_nx  = carrier;
    phase_nx    = phase;
    load        = 1'b0;
    load_word   = buf_data;

    // Any accepted word lands in the holding register unless it
    // is consumed directly below.
    if (xfer) begin
      buf_full_nx = 1'b1;
      buf_data_nx = s_data;
    end

    unique case (state)
      IDLE: begin
        if (enable && buf_full) begin
          load        = 1'b1;
          load_word   = buf_data;
          buf_full_nx = 1'b0;
        end else if (enable && xfer) begin
          load        = 1'b1;
          load_word   = s_data;
          buf_full_nx = 1'b0;
          buf_data_nx = buf_data;
        end
      end
      SEND: begin
        if (enable) begin
          if (!clk_term) begin
            clk_cnt_nx = clk_cnt + CW'(1);
          end else begin
            clk_cnt_nx = '0;
            carrier_nx = ~carrier;
            if (!half_term) begin
              half_cnt_nx = half_cnt + HW'(1);
            end else if (!last_bit) begin
              bit_idx_nx  = bit_idx + IW'(1);
              half_cnt_nx = '0;
              carrier_nx  = 1'b0;
              phase_nx    = coded(phase,
                              pick(shreg, bit_idx + IW'(1)));
            end else if (buf_full) begin
              load        = 1'b1;
              load_word   = buf_data;
              buf_full_nx = 1'b0;
            end else if (xfer) begin
              load        = 1'b1;
              load_word   = s_data;
              buf_full_nx = 1'b0;
              buf_data_nx = buf_data;
            end else begin
              state_nx    = IDLE;
              half_cnt_nx = '0;
              bit_idx_nx  = '0;
              carrier_nx  = 1'b0;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    // Word start: bit 0 phase is coded against the persisting reference.
    if (load) begin
      state_nx    = SEND;
      shreg_nx    = load_word;
      bit_idx_nx  = '0;
      clk_cnt_nx  = '0;
      half_cnt_nx = '0;
      carrier_nx  = 1'b0;
      phase_nx    = coded(phase, pick(load_word, '0));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      buf_full <= 1'b0;
      buf_data <= '0;
      shreg    <= '0;
      bit_idx  <= '0;
      clk_cnt  <= '0;
      half_cnt <= '0;
      carrier  <= 1'b0;
      phase    <= 1'b0;
    end else begin
      state    <= state_nx;
      buf_full <= buf_full_nx;
      buf_data <= buf_data_nx;
      shreg    <= shreg_nx;
      bit_idx  <= bit_idx_nx;
      clk_cnt  <= clk_cnt_nx;
      half_cnt <= half_cnt_nx;
      carrier  <= carrier_nx;
      phase    <= phase_nx;
    end
  end

endmodule

// File: tb/tb_bpsk_tx_stream.sv
// Directed bench: absolute LSB-first instance (a) and DBPSK MSB-first
// instance (d), HALF_DIV=4, one carrier period per bit.
module tb_bpsk_tx_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       enable;
  logic [7:0] data_a, data_d;
  logic       valid_a, valid_d;
  logic       ready_a, wave_a, busy_a, strobe_a, done_a;
  logic       ready_d, wave_d, busy_d, strobe_d, done_d;

  int total = 0;
  int fails = 0;

  logic [63:0] wv, st, wd;
  logic [7:0]  words [3];
  logic        x;
  int nx, run, maxrun, nbusy, ndone, nrdy;
  int first_done, frozen_ok, pulses;

  bpsk_tx_stream #(
    .CLOCK_IN(16), .CLOCK_CARRIER(2), .DATA_WIDTH(8),
    .CYCLE_COUNT(1), .MSB_FIRST(1'b0), .DIFFERENTIAL(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .enable(enable),
    .s_data(data_a), .s_valid(valid_a), .s_ready(ready_a),
    .wave_out(wave_a), .busy(busy_a),
    .bit_strobe(strobe_a), .word_done(done_a)
  );

  bpsk_tx_stream #(
    .CLOCK_IN(16), .CLOCK_CARRIER(2), .DATA_WIDTH(8),
    .CYCLE_COUNT(1), .MSB_FIRST(1'b1), .DIFFERENTIAL(1'b1)
  ) dut_d (
    .clk(clk), .rst(rst), .enable(enable),
    .s_data(data_d), .s_valid(valid_d), .s_ready(ready_d),
    .wave_out(wave_d), .busy(busy_d),
    .bit_strobe(strobe_d), .word_done(done_d)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word; returns at the first SEND clock (sample 1).
  task automatic send(input bit d, input logic [7:0] w);
    if (d) begin
      data_d  = w;
      valid_d = 1'b1;
      #1;
      chk("send ready d", 64'(ready_d), 64'd1);
    end else begin
      data_a  = w;
      valid_a = 1'b1;
      #1;
      chk("send ready a", 64'(ready_a), 64'd1);
    end
    tick();
    valid_a = 1'b0;
    valid_d = 1'b0;
  endtask

  // Samples clocks 1..64; clock 1 ends up in bit 63.
  task automatic collect(input bit d,
                         output logic [63:0] w,
                         output logic [63:0] s,
                         output logic [63:0] dn);
    w  = '0;
    s  = '0;
    dn = '0;
    for (int i = 1; i <= 64; i++) begin
      w  = {w[62:0],  d ? wave_d   : wave_a};
      s  = {s[62:0],  d ? strobe_d : strobe_a};
      dn = {dn[62:0], d ? done_d   : done_a};
      if (i < 64) tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    enable  = 1'b1;
    data_a  = 8'h3C;
    data_d  = 8'h3C;
    valid_a = 1'b1;
    valid_d = 1'b1;

    // Reset held 3 cycles with valid asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst busy",  {busy_a, busy_d},   64'd0);
      chk("rst wave",  {wave_a, wave_d},   64'd0);
      chk("rst ready", {ready_a, ready_d}, 64'd0);
    end
    rst = 1'b0;
    #1;
    chk("ready after rst", {ready_a, ready_d}, 64'd3);
    valid_a = 1'b0;
    valid_d = 1'b0;
    tick();
    chk("idle after rst",
        {busy_a, busy_d, wave_a, wave_d}, 64'd0);

    // Absolute, LSB first, 0xA5: bits 1,0,1,0,0,1,0,1
    send(1'b0, 8'hA5);
    collect(1'b0, wv, st, wd);
    chk("a5 wave",   wv, 64'hF00F_F00F_0FF0_0FF0);
    chk("a5 strobe", st, 64'h8080_8080_8080_8080);
    chk("a5 done",   wd, 64'h0000_0000_0000_0001);
    tick();
    chk("a5 idle", 64'(busy_a), 64'd0);

    // DBPSK, MSB first, 0x81 then 0x01
    send(1'b1, 8'h81);
    collect(1'b1, wv, st, wd);
    chk("81 wave", wv, 64'hF0F0_F0F0_F0F0_F00F);
    chk("81 done", wd, 64'h0000_0000_0000_0001);
    tick();
    chk("81 idle", 64'(busy_d), 64'd0);
    tick();
    tick();
    send(1'b1, 8'h01);
    collect(1'b1, wv, st, wd);
    chk("01 wave",   wv, 64'h0F0F_0F0F_0F0F_0FF0);
    chk("01 strobe", st, 64'h8080_8080_8080_8080);
    tick();

    // Back-to-back streaming on instance a
    words[0] = 8'h0F;
    words[1] = 8'hF0;
    words[2] = 8'h55;
    data_a  = words[0];
    valid_a = 1'b1;
    nx = 0; run = 0; maxrun = 0;
    nbusy = 0; ndone = 0; nrdy = 0;
    for (int i = 0; i < 260; i++) begin
      x = valid_a & ready_a;
      if (busy_a) begin
        run++;
        nbusy++;
        if (ready_a) nrdy++;
      end else begin
        run = 0;
      end
      if (run > maxrun) maxrun = run;
      if (done_a) ndone++;
      tick();
      if (x) begin
        nx++;
        if (nx < 3) data_a = words[nx];
        else valid_a = 1'b0;
      end
    end
    chk("b2b transfers", 64'(nx),     64'd3);
    chk("b2b run",       64'(maxrun), 64'd192);
    chk("b2b busy",      64'(nbusy),  64'd192);
    chk("b2b done",      64'(ndone),  64'd3);
    // ready at clocks 1 and 65, then 129..192 once valid is gone
    chk("b2b ready",     64'(nrdy),   64'd66);

    // Freeze 10 clocks from clock 3 of bit 2
    send(1'b0, 8'hA5);
    first_done = 0;
    frozen_ok  = 0;
    pulses     = 0;
    for (int i = 1; i <= 100; i++) begin
      if (i == 19) begin
        enable = 1'b0;
        #1;
      end
      if (i == 29) begin
        enable = 1'b1;
        #1;
      end
      if (i >= 19 && i <= 28) begin
        if (wave_a) frozen_ok++;
        if (strobe_a || done_a) pulses++;
      end
      if (done_a && first_done == 0) first_done = i;
      tick();
    end
    chk("frz done clk", 64'(first_done), 64'd74);
    chk("frz wave",     64'(frozen_ok),  64'd10);
    chk("frz pulses",   64'(pulses),     64'd0);
    chk("frz idle",     64'(busy_a),     64'd0);

    // Reset mid-word with a queued word on instance d
    send(1'b1, 8'h80);
    data_d  = 8'h55;
    valid_d = 1'b1;
    tick();
    valid_d = 1'b0;
    chk("queued ready", 64'(ready_d), 64'd0);
    for (int i = 2; i < 20; i++) tick();
    chk("pre-rst busy", 64'(busy_d), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("post-rst state",
        {busy_d, wave_d, ready_d}, 64'd1);
    tick();
    chk("queue dropped", 64'(busy_d), 64'd0);
    send(1'b1, 8'h80);
    collect(1'b1, wv, st, wd);
    chk("80 phase clr", wv, 64'hF0F0_F0F0_F0F0_F0F0);
    tick();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
